// File: rtl/inject_arbiter.sv
// -----------------------------------------------------------------------------
// inject_arbiter
//
// Merges the management-application (MA) and user-application (app) injector
// streams onto the single NoC injection port. Arbitration is per packet. A
// packet is a header flit, a size flit, and then `size` payload flits. Once a
// source is granted, its flits pass straight through with no added latency.
// The grant is held until the last flit of the packet has been transferred.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   ma_rx_i / ma_data_i    MA source flit valid / flit
//   ma_credit_o            MA source may transfer this cycle
//   app_rx_i / app_data_i  app source flit valid / flit
//   app_credit_o           app source may transfer this cycle
//   tx_o / data_o          flit valid / flit toward the NoC
//   credit_i               NoC accepts a flit this cycle
//   owner_o                current or last grant (0 = MA, 1 = app)
//   busy_o                 a packet is in flight
//
// Parameters
//   FLIT_SIZE    flit width in bits
//   MA_PRIORITY  1: MA wins every tie; 0: round-robin on ties
// -----------------------------------------------------------------------------
module inject_arbiter #(
  parameter int unsigned FLIT_SIZE   = 32,
  parameter bit          MA_PRIORITY = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 ma_rx_i,
  output logic                 ma_credit_o,
  input  logic [FLIT_SIZE-1:0] ma_data_i,

  input  logic                 app_rx_i,
  output logic                 app_credit_o,
  input  logic [FLIT_SIZE-1:0] app_data_i,

  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,

  output logic                 owner_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    SIZE    = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  localparam logic SRC_MA  = 1'b0;
  localparam logic SRC_APP = 1'b1;

  localparam logic [FLIT_SIZE-1:0] CNT_ZERO = '0;
  localparam logic [FLIT_SIZE-1:0] CNT_ONE  = FLIT_SIZE'(1);

  state_t               state;
  state_t               state_next;
  logic                 owner;
  logic                 owner_next;
  logic                 last_owner;
  logic                 last_owner_next;
  logic [FLIT_SIZE-1:0] cnt;
  logic [FLIT_SIZE-1:0] cnt_next;

  logic                 any_req;
  logic                 winner;
  logic                 grant_rx;
  logic [FLIT_SIZE-1:0] grant_data;
  logic                 xfer;

  // ---------------------------------------------------------------------------
  // Datapath helpers shared by the next-state and output logic
  // ---------------------------------------------------------------------------
  assign any_req    = ma_rx_i | app_rx_i;
  assign grant_rx   = (owner == SRC_APP) ? app_rx_i   : ma_rx_i;
  assign grant_data = (owner == SRC_APP) ? app_data_i : ma_data_i;

  // A flit moves toward the NoC only when a packet is in flight, the granted
  // source offers a flit, and the NoC has room for it.
  assign xfer = (state != IDLE) && grant_rx && credit_i;

  // Winner among the current requesters. On a tie in round-robin mode, the
  // source that did not own the previous packet wins. last_owner resets to
  // app, so MA wins the first tie after reset.
  always_comb begin
    winner = SRC_MA;
    if (ma_rx_i && app_rx_i) begin
      winner = MA_PRIORITY ? SRC_MA : ~last_owner;
    end else if (app_rx_i) begin
      winner = SRC_APP;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      owner      <= SRC_MA;
      last_owner <= SRC_APP;
      cnt        <= CNT_ZERO;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
      cnt        <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a hold-value default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_owner_next = last_owner;
    cnt_next        = cnt;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = HEADER;
          owner_next = winner;
        end
      end

      HEADER: begin
        if (xfer) begin
          state_next = SIZE;
        end
      end

      SIZE: begin
        if (xfer) begin
          cnt_next = grant_data;
          if (grant_data == CNT_ZERO) begin
            // A header-only packet ends on its size flit.
            state_next      = IDLE;
            last_owner_next = owner;
          end else begin
            state_next = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (xfer) begin
          cnt_next = cnt - CNT_ONE;
          // The packet ends on the transfer that finds cnt at 1. The count is
          // never decremented while it is already 0, so a maximum-size packet
          // cannot wrap.
          if (cnt == CNT_ONE) begin
            state_next      = IDLE;
            last_owner_next = owner;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // While a packet is in flight, the granted source sees the NoC credit
  // directly. This is what gives zero added latency. The other source is held
  // off. In IDLE nothing is forwarded, and data_o shows the MA flit so that
  // the bus stays deterministic.
  always_comb begin
    tx_o         = 1'b0;
    ma_credit_o  = 1'b0;
    app_credit_o = 1'b0;
    data_o       = ma_data_i;

    if (state != IDLE) begin
      tx_o   = grant_rx;
      data_o = grant_data;
      if (owner == SRC_APP) begin
        app_credit_o = credit_i;
      end else begin
        ma_credit_o  = credit_i;
      end
    end
  end

  assign owner_o = owner;
  assign busy_o  = (state != IDLE);

endmodule

// File: doc/inject_arbiter.md
# inject_arbiter

Packet-granular arbiter that merges the two injector streams (management-application source and user-application source) onto the single NoC injection port of the many-core. Each source delivers Hermes-style packets (header flit, size flit, then `size` payload flits) over a rx/credit handshake. The arbiter grants one source at a time and never interleaves flits of different packets. It forwards flits with zero added latency once granted.

## Interface
Parameters:
- `FLIT_SIZE`, 32, flit width in bits.
- `MA_PRIORITY`, 1, 1: MA source wins every tie; 0: round-robin on ties.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `ma_rx_i` in 1: MA source flit valid.
- `ma_credit_o` out 1: MA source may transfer.
- `ma_data_i` in FLIT_SIZE: MA source flit.
- `app_rx_i` in 1: app source flit valid.
- `app_credit_o` out 1: app source may transfer.
- `app_data_i` in FLIT_SIZE: app source flit.
- `tx_o` out 1: flit valid toward NoC.
- `credit_i` in 1: NoC accepts flit.
- `data_o` out FLIT_SIZE: flit toward NoC.
- `owner_o` out 1: current/last grant, 0 = MA, 1 = app.
- `busy_o` out 1: a packet is in flight (state ≠ IDLE).

## Operation
- Transfer on any link occurs in a cycle where rx/tx and credit are both high.
- FSM states: IDLE, HEADER, SIZE, PAYLOAD.
- IDLE: `tx_o`=0, both source credits 0. If any source rx high, register winner into `owner_o`, go HEADER next cycle. No request: stay.
- Winner selection: only one requesting → it wins. Both requesting → `MA_PRIORITY`=1: MA; `MA_PRIORITY`=0: the source not in `last_owner` register. `last_owner` resets to app, so MA wins the first tie.
- In HEADER/SIZE/PAYLOAD:
  - `tx_o` = granted rx.
  - `data_o` = granted data.
  - Granted credit = `credit_i`.
  - Non-granted credit = 0.
  - All of these are combinational.
- HEADER: on transfer → SIZE.
- SIZE: on transfer, load `cnt` ← `data_o`. If value is 0 → IDLE; else → PAYLOAD.
- PAYLOAD: on transfer, `cnt` ← `cnt`−1. If `cnt`==1 at transfer → IDLE.
- On return to IDLE, `last_owner` ← `owner_o`.
- `data_o` in IDLE = MA data (don't-care, but deterministic).
- `cnt` is FLIT_SIZE bits wide, unsigned. Size 0xFFFFFFFF is legal and handled without wrap: the counter never decrements past 1 within a packet.

## Timing
- Reset values:
  - `tx_o`=0, `ma_credit_o`=0, `app_credit_o`=0.
  - `owner_o`=0, `busy_o`=0.
  - state IDLE, `cnt`=0, `last_owner`=1.
- Grant latency: request seen in IDLE at cycle N. First flit can transfer at cycle N+1.
- Packet boundary: one IDLE bubble cycle between consecutive packets, even from the same source.
- Source dropping rx mid-packet: arbiter holds state and grant indefinitely. No timeout, no preemption.
- `credit_i` low: granted source credit low the same cycle. State and `cnt` hold.
- A request from the other source mid-packet is ignored until IDLE. It is then arbitrated normally.
- Reset asserted mid-packet: immediately (async) return to reset values. The partial packet is abandoned.

## Test plan
- MA-only packet: header 0x0000_0102, size 3, payloads A,B,C, `credit_i`=1 → `tx_o` high 5 consecutive cycles starting 1 cycle after request; `data_o` sequence matches; `busy_o` falls after C; `app_credit_o` stays 0.
- Simultaneous requests, `MA_PRIORITY`=0, both sending size-2 packets repeatedly → grants alternate MA, app, MA, app; `owner_o` toggles; no flit interleaving; exactly one IDLE cycle between packets.
- Same tie, `MA_PRIORITY`=1, MA sends 3 back-to-back packets → all three MA packets precede the app packet.
- Size-0 packet from app → exactly 2 flits forwarded (header, size); FSM back to IDLE the cycle after the size transfer.
- Backpressure: `credit_i` toggles 1,0,0,1 during payload, and the source drops rx for 2 cycles → no flit lost or duplicated; `cnt` reaches end exactly after the last payload flit.
- Reset mid-payload (after 2 of 5 payloads) → all outputs return to reset values asynchronously; the next request is granted cleanly with a fresh header.
